// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one memory read/write port, one grant per cycle.
// Fixed priority by default; define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                req_valid,
    input  logic [NUM_PORTS-1:0]                req_wr,
    input  logic [NUM_PORTS*(ADDR_WIDTH-2)-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]                req_ready,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic [ADDR_WIDTH-3:0]               mem_raddr,
    output logic [ADDR_WIDTH-3:0]               mem_waddr,
    output logic                                mem_rden,
    output logic                                mem_wren,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic [DATA_WIDTH-1:0]               mem_rdata,
    output logic [31:0]                         contention_cnt
);

    localparam int unsigned AW = ADDR_WIDTH - 2;
    localparam int unsigned DW = DATA_WIDTH;

    logic [NUM_PORTS-1:0] grant;
    logic                 any_grant;
    logic                 found;
    logic                 sel_wr;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic                 contended;

    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [DW-1:0]        rsp_rdata_q;
    logic [31:0]          cnt_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            rot;

    // Walk ports in order ptr, ptr+1, ... (wrapping); the first valid one wins.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        rot   = 0;
        if (rst_n) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                rot = int'(ptr_q) + k;
                if (rot >= int'(NUM_PORTS)) begin
                    rot = rot - int'(NUM_PORTS);
                end
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (!found && (i == rot) && req_valid[i]) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        ptr_d    = (i == int'(NUM_PORTS) - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Lowest valid index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (rst_n) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (!found && req_valid[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                end
            end
        end
    end
`endif

    assign any_grant = |grant;
    assign req_ready = grant;

    // One-hot AND-OR mux: everything is zero when nothing is granted.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            sel_wr    = sel_wr    | (req_wr[i] & grant[i]);
            sel_addr  = sel_addr  | (req_addr[i*AW +: AW] & {AW{grant[i]}});
            sel_wdata = sel_wdata | (req_wdata[i*DW +: DW] & {DW{grant[i]}});
        end
    end

    assign mem_rden  = any_grant & ~sel_wr;
    assign mem_wren  = any_grant & sel_wr;
    assign mem_raddr = sel_addr & {AW{mem_rden}};
    assign mem_waddr = sel_addr & {AW{mem_wren}};
    assign mem_wdata = sel_wdata & {DW{mem_wren}};

    assign contended = ($countones(req_valid) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= grant;
            if (any_grant) begin
                rsp_rdata_q <= mem_rden ? mem_rdata : '0;
            end
            if (contended && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (3 ports): directed scenarios then random traffic,
// checked against a spec-level model of grant choice, memory contents and contention count.
module tb_mem_port_arbiter;

    localparam int unsigned NP         = 3;
    localparam int unsigned ADDR_WIDTH = 11;
    localparam int unsigned AW         = ADDR_WIDTH - 2;
    localparam int unsigned DW         = 32;
    localparam int unsigned MEM_WORDS  = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_wr;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_raddr;
    logic [AW-1:0]     mem_waddr;
    logic              mem_rden;
    logic              mem_wren;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [31:0]       contention_cnt;

    mem_port_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_raddr     (mem_raddr),
        .mem_waddr     (mem_waddr),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(int unsigned a);
        if (a == 5) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural memory attached to the DUT's memory port.
    logic [DW-1:0] sim_mem [MEM_WORDS];
    assign mem_rdata = sim_mem[mem_raddr];
    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) sim_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_wren) sim_mem[mem_waddr] = mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_wr [int];
    int            model_ptr = 0;
    logic [31:0]   model_cnt = '0;
    int            preload_seq = 0;
    int            seen_seq = 0;
    localparam logic [31:0] PRELOAD = 32'hFFFF_FFFE;

    function automatic logic [DW-1:0] ref_read(int a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return init_val(a);
    endfunction

    // First valid port at or after ptr with wrap; fixed priority is the same search from 0.
    function automatic int pick_port(logic [NP-1:0] v, int ptr);
        for (int k = 0; k < int'(NP); k++) begin
            int idx = (ptr + k) % int'(NP);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    int            p_g;
    int            p_a;
    logic          p_w;
    logic [DW-1:0] p_d;
    logic [NP-1:0] p_ready;
    logic [51:0]   p_mem;

    // Predictor: computes what the DUT must show this cycle and what it must answer next cycle.
    always @(negedge clk) begin
        if (preload_seq != seen_seq) begin
            model_cnt = PRELOAD;
            seen_seq  = preload_seq;
        end
        if (!rst_n) begin
            exp_q.delete();
            model_ptr = 0;
            model_cnt = '0;
            chk("rst_ready", req_ready, '0);
            chk("rst_mem", {mem_rden, mem_wren, mem_raddr, mem_waddr, mem_wdata}, '0);
            chk("rst_cnt", contention_cnt, '0);
        end else begin
            p_g     = pick_port(req_valid, model_ptr);
            p_ready = '0;
            p_mem   = '0;
            if (p_g >= 0) begin
                p_ready[p_g] = 1'b1;
                p_w = req_wr[p_g];
                p_a = int'(req_addr[p_g*AW +: AW]);
                p_d = req_wdata[p_g*DW +: DW];
                if (p_w) begin
                    p_mem = {1'b0, 1'b1, AW'(0), AW'(p_a), p_d};
                    ref_wr[p_a] = p_d;
                    exp_q.push_back('{port: p_g, data: '0, due: cyc + 1});
                end else begin
                    p_mem = {1'b1, 1'b0, AW'(p_a), AW'(0), DW'(0)};
                    exp_q.push_back('{port: p_g, data: ref_read(p_a), due: cyc + 1});
                end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                model_ptr = (p_g + 1) % int'(NP);
`endif
            end
            chk("req_ready", req_ready, p_ready);
            chk("mem_port", {mem_rden, mem_wren, mem_raddr, mem_waddr, mem_wdata}, p_mem);
            chk("contention_cnt", contention_cnt, model_cnt);
            if ($countones(req_valid) >= 2 && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 1;
        end
    end

    exp_t m_e;

    // Monitor: pops the response that is due this cycle, otherwise requires silence.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp", {rsp_valid, rsp_rdata}, '0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, NP'(1) << m_e.port);
            chk("rsp_rdata", rsp_rdata, m_e.data);
        end else begin
            chk("rsp_idle", rsp_valid, '0);
        end
    end

    // ---------------- stimulus ----------------
    logic [NP-1:0] drv_g;

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_wr    = '0;
        req_wdata = '0;
        req_addr  = '0;
        for (int i = 0; i < int'(NP); i++) req_addr[i*AW +: AW] = AW'(i + 8);

        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, '0);
        chk("reset_wren", mem_wren, 1'b0);
        chk("reset_cnt", contention_cnt, '0);

        // All ports valid from the first cycle out of reset.
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("arb_order", req_ready, NP'(1) << (k % 3));
`else
            chk("arb_order", req_ready, NP'(1));
`endif
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("contention_six", contention_cnt, 32'd6);

        // Single read by port 1.
        @(posedge clk); #1;
        req_valid = 3'b010; req_wr = '0; req_addr[AW +: AW] = AW'(5);
        @(negedge clk);
        chk("rd_raddr", mem_raddr, AW'(5));
        chk("rd_rden", mem_rden, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 3'b010);
        chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Single write by port 0.
        @(posedge clk); #1;
        req_valid = 3'b001; req_wr = 3'b001;
        req_addr[0 +: AW] = AW'(9'h1F); req_wdata[0 +: DW] = 32'h1234_5678;
        @(negedge clk);
        chk("wr_wren", mem_wren, 1'b1);
        chk("wr_waddr", mem_waddr, AW'(9'h1F));
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        @(posedge clk); #1 req_valid = '0; req_wr = '0;
        @(negedge clk);
        chk("wr_rsp_valid", rsp_valid, 3'b001);
        chk("wr_rdata", rsp_rdata, '0);
        chk("wr_wren_drop", mem_wren, 1'b0);

        // Reset lands between a grant to port 1 and the edge that would respond.
        @(posedge clk); #1 req_valid = 3'b001;
        @(posedge clk); #1 req_valid = 3'b010;
        @(negedge clk);
        chk("mid_grant", req_ready, 3'b010);
        #2 rst_n = 1'b0;
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("mid_no_rsp", rsp_valid, '0);
        @(posedge clk); #1 rst_n = 1'b1; req_valid = '1;
        @(negedge clk);
        chk("mid_no_rsp_after", rsp_valid, '0);
        chk("mid_ptr_zero", req_ready, 3'b001);
        @(posedge clk); #1 req_valid = '0;

        // Counter saturation from a preloaded value.
        @(posedge clk); #1;
        force dut.cnt_q = PRELOAD;
        #1 release dut.cnt_q;
        preload_seq++;
        req_valid = 3'b011;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("cnt_saturate", contention_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("cnt_hold", contention_cnt, 32'hFFFF_FFFF);

        // Fresh reset, then random traffic obeying the hold-until-ready rule.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            drv_g = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < int'(NP); i++) begin
                if (!req_valid[i] || drv_g[i]) begin
                    req_valid[i]          = ($urandom_range(0, 99) < 55);
                    req_wr[i]             = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of requester ports (1..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 11, meaning the byte-address width of the memory; word address is ADDR_WIDTH-2 bits (AW).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width (DW).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid  input  NUM_PORTS  per-port request valid.
REQ-007 The block SHALL have port req_wr  input  NUM_PORTS  per-port request type (1 write, 0 read).
REQ-008 The block SHALL have port req_addr  input  NUM_PORTS*AW  per-port word address; port i occupies bits [i*AW +: AW].
REQ-009 The block SHALL have port req_wdata  input  NUM_PORTS*DW  per-port write data.
REQ-010 The block SHALL have port req_ready  output  NUM_PORTS  per-port grant, one-hot or zero.
REQ-011 The block SHALL have port rsp_valid  output  NUM_PORTS  per-port response pulse.
REQ-012 The block SHALL have port rsp_rdata  output  DW  registered read data, shared by all ports.
REQ-013 The block SHALL have ports mem_raddr/mem_waddr  output  AW each, mem_rden/mem_wren  output  1 each, mem_wdata  output  DW  memory side.
REQ-014 The block SHALL have port mem_rdata  input  DW  combinational read data from memory.
REQ-015 The block SHALL have port contention_cnt  output  32  cycles with two or more simultaneous valid requests.

Function
REQ-016 At most one port SHALL be granted per cycle; req_ready[i] is combinational from req_valid and arbitration state.
REQ-017 A request SHALL complete in the cycle in which req_valid[i] and req_ready[i] are both high.
REQ-018 A granted read SHALL drive mem_rden=1 and mem_raddr=req_addr of port i in the grant cycle; mem_rdata SHALL be captured into rsp_rdata at the following edge.
REQ-019 A granted write SHALL drive mem_wren=1, mem_waddr and mem_wdata from port i in the grant cycle.
REQ-020 rsp_valid[i] SHALL pulse for exactly one cycle, the cycle after the grant to port i, for both reads and writes.
REQ-021 For a write response, rsp_rdata SHALL read 0.
REQ-022 With no grant, mem_rden, mem_wren, mem_raddr, mem_waddr and mem_wdata SHALL be 0 (AND-masked, no stale values).
REQ-023 Arbitration SHALL be governed by a round-robin pointer ptr, range 0..NUM_PORTS-1: first valid port at or after ptr wins, searching upward with wrap.
REQ-024 After each grant to port g, ptr SHALL become g+1, wrapping from NUM_PORTS-1 to 0; with no grant ptr holds.
REQ-025 With NUM_PORTS=1, ptr SHALL be constant 0 and req_ready[0] SHALL equal req_valid[0].
REQ-026 contention_cnt SHALL increment by 1 each cycle with popcount(req_valid)>=2 and saturate at 0xFFFFFFFF.
REQ-027 Requesters SHALL hold req_wr, req_addr and req_wdata stable while valid and not ready; the block does not check this.

Reset
REQ-028 While rst_n=0: ptr=0, rsp_valid=0, rsp_rdata=0, contention_cnt=0, req_ready=0, all mem_* outputs 0.
REQ-029 Assertion of rst_n mid-transaction SHALL discard any pending response; no rsp_valid pulse follows reset release.
REQ-030 The first grant SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-031 With macro MEM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-023/REQ-024.
REQ-032 Without MEM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority (lowest valid index wins), ptr SHALL not exist, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Reset: rst_n=0 with all req_valid=1 -> req_ready=0, mem_wren=0, contention_cnt=0.
REQ-034 Single read: port 1 reads addr 0x05 with mem_rdata=0xDEADBEEF -> mem_raddr=0x05 in grant cycle; next cycle rsp_valid=2'b10, rsp_rdata=0xDEADBEEF.
REQ-035 Round-robin, NUM_PORTS=3, all valid for 6 cycles -> grant order 0,1,2,0,1,2; contention_cnt=6; fixed-priority build grants port 0 every cycle.
REQ-036 Write: port 0 writes 0x12345678 to addr 0x1F -> mem_wren=1, mem_waddr=0x1F, mem_wdata=0x12345678 for one cycle; next cycle rsp_valid[0]=1, rsp_rdata=0.
REQ-037 Reset mid-operation: grant read to port 1, drop rst_n before next edge -> rsp_valid stays 0, ptr returns 0.
REQ-038 Saturation: preload contention_cnt to 0xFFFFFFFE via force, two ports valid for 3 cycles -> counter reads 0xFFFFFFFF and holds.
